// File: rtl/box_renderer_pkg.sv
// Shared game constants for the box renderer.
//   SCREEN_W/SCREEN_H : visible frame size in pixels
//   *_COLOUR          : 3-bit RGB colours for the box and background
//   state_e           : renderer FSM encoding
package box_renderer_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] FLY_COLOUR  = 3'b110;
  localparam logic [2:0] FALL_COLOUR = 3'b011;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/box_scan_counter.sv
// Row-major dx/dy scan counter over a BOX_SIZE x BOX_SIZE square.
//   CLOCK_50 : clock
//   resetn   : asynchronous active-low reset
//   start    : restart the scan at (0,0)
//   advance  : step to the next pixel (dx fastest, dy on dx wrap)
//   dx, dy   : current pixel offset
//   last     : current pixel is the final one of the square
module box_scan_counter #(
  parameter int unsigned BOX_SIZE = 4,
  parameter int unsigned CW       = $clog2(BOX_SIZE)
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic          advance,
  output logic [CW-1:0] dx,
  output logic [CW-1:0] dy,
  output logic          last
);

  localparam logic [CW-1:0] MaxIdx = CW'(BOX_SIZE - 1);

  logic [CW-1:0] dx_q, dy_q;

  // BOX_SIZE is a power of two, so dy wraps to 0 after the last row on its own;
  // this lets ERASE roll straight into DRAW without an explicit restart.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (start) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (advance) begin
      if (dx_q == MaxIdx) begin
        dx_q <= '0;
        dy_q <= dy_q + CW'(1);
      end else begin
        dx_q <= dx_q + CW'(1);
      end
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == MaxIdx) && (dy_q == MaxIdx);

endmodule

// File: rtl/box_renderer.sv
// Per-tick box renderer: erases the box at its previous row, then draws it at
// the newly sampled row, one pixel per clock to the VGA plot port.
//   CLOCK_50, resetn        : clock, asynchronous active-low reset
//   game_tick               : one-cycle frame pulse, honoured only when idle
//   y_coordinate, flying    : box row and status from the box register
//   x_out, y_out, colour    : registered pixel address and colour
//   plot                    : registered pixel write enable
//   busy, frame_done        : update in progress / one-cycle completion pulse
module box_renderer #(
  parameter int unsigned BOX_X       = 20,
  parameter int unsigned BOX_SIZE    = 4,
  parameter int unsigned SCREEN_H    = box_renderer_pkg::SCREEN_H,
  parameter logic [2:0]  FLY_COLOUR  = box_renderer_pkg::FLY_COLOUR,
  parameter logic [2:0]  FALL_COLOUR = box_renderer_pkg::FALL_COLOUR,
  parameter logic [2:0]  BG_COLOUR   = box_renderer_pkg::BG_COLOUR
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       game_tick,
  input  logic [6:0] y_coordinate,
  input  logic       flying,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  import box_renderer_pkg::*;

  localparam int unsigned CW = $clog2(BOX_SIZE);

  state_e     state_q, state_d;
  logic [6:0] new_y_q, new_y_d;
  logic [2:0] new_col_q, new_col_d;
  logic [6:0] old_y_q, old_y_d;
  logic       have_old_q, have_old_d;

  logic          scan_start, scan_advance, scan_last;
  logic [CW-1:0] dx, dy;

  logic       scanning;
  logic [6:0] base_y;
  logic [7:0] sum_y;
  logic [2:0] pix_col;

  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] colour_d;
  logic       plot_d, busy_d, frame_done_d;

  box_scan_counter #(
    .BOX_SIZE (BOX_SIZE),
    .CW       (CW)
  ) u_scan (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (scan_start),
    .advance  (scan_advance),
    .dx       (dx),
    .dy       (dy),
    .last     (scan_last)
  );

  always_comb begin
    state_d      = state_q;
    new_y_d      = new_y_q;
    new_col_d    = new_col_q;
    old_y_d      = old_y_q;
    have_old_d   = have_old_q;
    scan_start   = 1'b0;
    scan_advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (game_tick) begin
          new_y_d    = y_coordinate;
          new_col_d  = flying ? FLY_COLOUR : FALL_COLOUR;
          scan_start = 1'b1;
          state_d    = have_old_q ? ERASE : DRAW;
        end
      end
      ERASE: begin
        scan_advance = 1'b1;
        if (scan_last) state_d = DRAW;
      end
      DRAW: begin
        scan_advance = 1'b1;
        if (scan_last) begin
          old_y_d    = new_y_q;
          have_old_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered pixel stream: the current scan position becomes the output
  // pixel on the next edge. Clipped rows still burn their cycle with plot low.
  always_comb begin
    scanning     = (state_q == ERASE) || (state_q == DRAW);
    base_y       = (state_q == ERASE) ? old_y_q : new_y_q;
    pix_col      = (state_q == ERASE) ? BG_COLOUR : new_col_q;
    sum_y        = {1'b0, base_y} + 8'(dy);
    x_d          = scanning ? 8'(BOX_X) + 8'(dx) : x_out;
    y_d          = scanning ? sum_y[6:0] : y_out;
    colour_d     = scanning ? pix_col : colour;
    plot_d       = scanning && (32'(sum_y) < SCREEN_H);
    busy_d       = (state_q != IDLE);
    frame_done_d = (state_q == DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      new_y_q    <= '0;
      new_col_q  <= '0;
      old_y_q    <= '0;
      have_old_q <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      new_y_q    <= new_y_d;
      new_col_q  <= new_col_d;
      old_y_q    <= old_y_d;
      have_old_q <= have_old_d;
      x_out      <= x_d;
      y_out      <= y_d;
      colour     <= colour_d;
      plot       <= plot_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_box_renderer.sv
// Directed self-checking bench for box_renderer (default parameters).
module tb_box_renderer;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       game_tick = 1'b0;
  logic [6:0] y_coordinate = '0;
  logic       flying = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, busy, frame_done;

  int checks = 0;
  int failures = 0;

  // Outputs recorded #1 after edge k+i, index i.
  logic [7:0] cap_x    [0:63];
  logic [6:0] cap_y    [0:63];
  logic [2:0] cap_col  [0:63];
  logic       cap_plot [0:63];
  logic       cap_busy [0:63];
  logic       cap_done [0:63];

  box_renderer dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .game_tick    (game_tick),
    .y_coordinate (y_coordinate),
    .flying       (flying),
    .x_out        (x_out),
    .y_out        (y_out),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Tick sampled at edge k; inputs then scrambled to show they are not re-sampled.
  // retick>0 raises game_tick again so it is sampled at edge k+retick.
  task automatic run_frame(input logic [6:0] y, input logic fl, input int n, input int retick);
    @(negedge CLOCK_50);
    y_coordinate = y;
    flying       = fl;
    game_tick    = 1'b1;
    @(posedge CLOCK_50);
    #1;
    game_tick    = 1'b0;
    y_coordinate = ~y;
    flying       = ~fl;
    for (int i = 1; i <= n; i++) begin
      game_tick = (i == retick);
      @(posedge CLOCK_50);
      #1;
      cap_x[i]    = x_out;
      cap_y[i]    = y_out;
      cap_col[i]  = colour;
      cap_plot[i] = plot;
      cap_busy[i] = busy;
      cap_done[i] = frame_done;
    end
    game_tick = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++;
    if ({x_out, y_out, colour, plot, busy, frame_done} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got x=%0d y=%0d c=%0d p=%b b=%b d=%b required all 0",
               x_out, y_out, colour, plot, busy, frame_done);
    end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLOCK_50);
      #1;
      checks++;
      if (plot !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d got p=%b b=%b d=%b required 0 0 0",
                 i, plot, busy, frame_done);
      end
    end
  endtask

  task automatic test_first_frame();
    run_frame(7'd60, 1'b1, 18, 0);
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] ex;
      logic [6:0] ey;
      ex = 8'(20 + (i - 1) % 4);
      ey = 7'(60 + (i - 1) / 4);
      checks++;
      if (cap_x[i] !== ex || cap_y[i] !== ey || cap_col[i] !== 3'b110 || cap_plot[i] !== 1'b1
          || cap_busy[i] !== 1'b1 || cap_done[i] !== 1'b0) begin
        failures++;
        $display("FAIL first_draw i=%0d got x=%0d y=%0d c=%0d p=%b b=%b d=%b required x=%0d y=%0d c=6 p=1 b=1 d=0",
                 i, cap_x[i], cap_y[i], cap_col[i], cap_plot[i], cap_busy[i], cap_done[i], ex, ey);
      end
    end
    checks++;
    if (cap_plot[17] !== 1'b0 || cap_done[17] !== 1'b1 || cap_busy[17] !== 1'b1) begin
      failures++;
      $display("FAIL first_done got p=%b d=%b b=%b required p=0 d=1 b=1",
               cap_plot[17], cap_done[17], cap_busy[17]);
    end
    checks++;
    if (cap_done[18] !== 1'b0 || cap_busy[18] !== 1'b0) begin
      failures++;
      $display("FAIL first_after got d=%b b=%b required 0 0", cap_done[18], cap_busy[18]);
    end
  endtask

  task automatic test_normal_frame();
    run_frame(7'd58, 1'b0, 34, 0);
    for (int i = 1; i <= 32; i++) begin
      logic [7:0] ex;
      logic [6:0] ey;
      logic [2:0] ec;
      int p;
      p  = (i - 1) % 16;
      ex = 8'(20 + p % 4);
      ey = (i <= 16) ? 7'(60 + p / 4) : 7'(58 + p / 4);
      ec = (i <= 16) ? 3'b000 : 3'b011;
      checks++;
      if (cap_x[i] !== ex || cap_y[i] !== ey || cap_col[i] !== ec || cap_plot[i] !== 1'b1
          || cap_done[i] !== 1'b0) begin
        failures++;
        $display("FAIL normal_pix i=%0d got x=%0d y=%0d c=%0d p=%b d=%b required x=%0d y=%0d c=%0d p=1 d=0",
                 i, cap_x[i], cap_y[i], cap_col[i], cap_plot[i], cap_done[i], ex, ey, ec);
      end
    end
    checks++;
    if (cap_plot[33] !== 1'b0 || cap_done[33] !== 1'b1 || cap_busy[33] !== 1'b1) begin
      failures++;
      $display("FAIL normal_done got p=%b d=%b b=%b required p=0 d=1 b=1",
               cap_plot[33], cap_done[33], cap_busy[33]);
    end
    checks++;
    if (cap_done[34] !== 1'b0 || cap_busy[34] !== 1'b0) begin
      failures++;
      $display("FAIL normal_after got d=%b b=%b required 0 0", cap_done[34], cap_busy[34]);
    end
  endtask

  task automatic test_clipping();
    run_frame(7'd118, 1'b1, 34, 0);
    for (int i = 17; i <= 32; i++) begin
      logic [6:0] ey;
      logic       ep;
      int p;
      p  = i - 17;
      ey = 7'(118 + p / 4);
      ep = (p / 4) < 2;
      checks++;
      if (cap_x[i] !== 8'(20 + p % 4) || cap_y[i] !== ey || cap_plot[i] !== ep) begin
        failures++;
        $display("FAIL clip_pix i=%0d got x=%0d y=%0d p=%b required x=%0d y=%0d p=%b",
                 i, cap_x[i], cap_y[i], cap_plot[i], 20 + p % 4, ey, ep);
      end
    end
    checks++;
    if (cap_done[33] !== 1'b1) begin
      failures++;
      $display("FAIL clip_done got d=%b required 1", cap_done[33]);
    end
  endtask

  task automatic test_tick_while_busy();
    int ndone;
    run_frame(7'd10, 1'b0, 40, 5);
    ndone = 0;
    for (int i = 1; i <= 40; i++) ndone += int'(cap_done[i]);
    checks++;
    if (ndone != 1 || cap_done[33] !== 1'b1) begin
      failures++;
      $display("FAIL busy_done_count got %0d (d33=%b) required 1 at k+33", ndone, cap_done[33]);
    end
    for (int i = 1; i <= 32; i++) begin
      logic [6:0] ey;
      logic [2:0] ec;
      logic       ep;
      int p;
      p  = (i - 1) % 16;
      ey = (i <= 16) ? 7'(118 + p / 4) : 7'(10 + p / 4);
      ec = (i <= 16) ? 3'b000 : 3'b011;
      ep = (i <= 16) ? ((p / 4) < 2) : 1'b1;
      checks++;
      if (cap_y[i] !== ey || cap_col[i] !== ec || cap_plot[i] !== ep) begin
        failures++;
        $display("FAIL busy_pix i=%0d got y=%0d c=%0d p=%b required y=%0d c=%0d p=%b",
                 i, cap_y[i], cap_col[i], cap_plot[i], ey, ec, ep);
      end
    end
    for (int i = 34; i <= 40; i++) begin
      checks++;
      if (cap_busy[i] !== 1'b0 || cap_plot[i] !== 1'b0) begin
        failures++;
        $display("FAIL busy_tail i=%0d got b=%b p=%b required 0 0", i, cap_busy[i], cap_plot[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    run_frame(7'd20, 1'b1, 10, 0);
    resetn = 1'b0;
    #1;
    checks++;
    if ({x_out, y_out, colour, plot, busy, frame_done} !== 21'd0) begin
      failures++;
      $display("FAIL midreset_outputs got x=%0d y=%0d c=%0d p=%b b=%b d=%b required all 0",
               x_out, y_out, colour, plot, busy, frame_done);
    end
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    run_frame(7'd40, 1'b1, 18, 0);
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] ex;
      logic [6:0] ey;
      ex = 8'(20 + (i - 1) % 4);
      ey = 7'(40 + (i - 1) / 4);
      checks++;
      if (cap_x[i] !== ex || cap_y[i] !== ey || cap_col[i] !== 3'b110 || cap_plot[i] !== 1'b1) begin
        failures++;
        $display("FAIL midreset_draw i=%0d got x=%0d y=%0d c=%0d p=%b required x=%0d y=%0d c=6 p=1",
                 i, cap_x[i], cap_y[i], cap_col[i], cap_plot[i], ex, ey);
      end
    end
    checks++;
    if (cap_done[17] !== 1'b1 || cap_plot[17] !== 1'b0) begin
      failures++;
      $display("FAIL midreset_done got d=%b p=%b required d=1 p=0", cap_done[17], cap_plot[17]);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_normal_frame();
    test_clipping();
    test_tick_while_busy();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
